// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : microcode_sequencer
// Description : Fetches opcode / 0xCB prefix / immediate bytes over a
//               byte-wide read handshake, presents the opcode to the microcode
//               decoder and steps through the execute cycles described by the
//               control word it returns.
// Revision    : 1.0 - initial release
// ============================================================================
module microcode_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          STEP_MSB = 59,
    parameter int          IMM1_BIT = 56,
    parameter int          IMM2_BIT = 55,
    parameter int          HALT_BIT = 54
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [59:0] control_signals,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    input  logic        pc_load,
    input  logic [15:0] pc_load_value,
    input  logic        irq_pending,
    output logic [7:0]  opcode,
    output logic        cb_prefix,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic [15:0] imm,
    output logic [2:0]  step,
    output logic        exec_valid,
    output logic [15:0] pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_PREFIX = 3'd1,
        S_DECODE = 3'd2,
        S_IMM_LO = 3'd3,
        S_IMM_HI = 3'd4,
        S_EXEC   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [7:0] c_CB_BYTE = 8'hCB;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [7:0]  r_opcode;
    logic        r_cb_prefix;
    logic [15:0] r_imm;
    logic [2:0]  r_step;
    logic        r_exec_valid;
    logic        r_mem_rd;
    logic        r_halted;

    logic        w_accept;
    logic [15:0] w_pc_inc;
    logic        w_last_step;
    logic        w_imm1;
    logic        w_imm2;
    logic        w_halt;
    logic        w_unused_ctrl;

    // A read completes only while a request is actually outstanding
    assign w_accept      = r_mem_rd & mem_ready;
    assign w_pc_inc      = r_pc + 16'd1;
    assign w_last_step   = (r_step == control_signals[STEP_MSB -: 3]);
    assign w_imm1        = control_signals[IMM1_BIT];
    assign w_imm2        = control_signals[IMM2_BIT];
    assign w_halt        = control_signals[HALT_BIT];
    assign w_unused_ctrl = ^control_signals;

    // Sequencer FSM: every output is a register updated alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_opcode     <= 8'h00;
            r_cb_prefix  <= 1'b0;
            r_imm        <= 16'h0000;
            r_step       <= 3'd0;
            r_exec_valid <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // Request line comes up one cycle after reset release
                    if (!r_mem_rd) begin
                        r_mem_rd <= 1'b1;
                    end else if (mem_ready) begin
                        r_pc <= w_pc_inc;
                        if (mem_rdata == c_CB_BYTE && !r_cb_prefix) begin
                            r_cb_prefix <= 1'b1;
                            r_state     <= S_PREFIX;
                        end else begin
                            r_opcode <= mem_rdata;
                            r_mem_rd <= 1'b0;
                            r_state  <= S_DECODE;
                        end
                    end
                end
                S_PREFIX: begin
                    if (w_accept) begin
                        r_pc     <= w_pc_inc;
                        r_opcode <= mem_rdata;
                        r_mem_rd <= 1'b0;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Control word has settled for the new opcode
                    if (w_imm1) begin
                        r_mem_rd <= 1'b1;
                        r_state  <= S_IMM_LO;
                    end else begin
                        r_step       <= 3'd0;
                        r_exec_valid <= 1'b1;
                        r_state      <= S_EXEC;
                    end
                end
                S_IMM_LO: begin
                    if (w_accept) begin
                        r_pc        <= w_pc_inc;
                        r_imm[7:0]  <= mem_rdata;
                        if (w_imm2) begin
                            r_state <= S_IMM_HI;
                        end else begin
                            r_mem_rd     <= 1'b0;
                            r_step       <= 3'd0;
                            r_exec_valid <= 1'b1;
                            r_state      <= S_EXEC;
                        end
                    end
                end
                S_IMM_HI: begin
                    if (w_accept) begin
                        r_pc         <= w_pc_inc;
                        r_imm[15:8]  <= mem_rdata;
                        r_mem_rd     <= 1'b0;
                        r_step       <= 3'd0;
                        r_exec_valid <= 1'b1;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_last_step) begin
                        // Jump requests only count on the final step
                        if (pc_load) begin
                            r_pc <= pc_load_value;
                        end
                        r_cb_prefix  <= 1'b0;
                        r_step       <= 3'd0;
                        r_exec_valid <= 1'b0;
                        if (w_halt) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_mem_rd <= 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                S_HALT: begin
                    if (irq_pending) begin
                        r_halted <= 1'b0;
                        r_mem_rd <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                default: begin
                    r_mem_rd     <= 1'b0;
                    r_exec_valid <= 1'b0;
                    r_halted     <= 1'b0;
                    r_state      <= S_FETCH;
                end
            endcase
        end
    end

    assign opcode     = r_opcode;
    assign cb_prefix  = r_cb_prefix;
    assign mem_addr   = r_pc;
    assign mem_rd     = r_mem_rd;
    assign imm        = r_imm;
    assign step       = r_step;
    assign exec_valid = r_exec_valid;
    assign pc         = r_pc;
    assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_microcode_sequencer
// Description : Self-checking bench for microcode_sequencer with a memory
//               responder, a decoder model and a fetch/execute scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microcode_sequencer;

    logic        clk;
    logic        rst;
    logic [59:0] control_signals;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        irq_pending;
    logic [7:0]  opcode;
    logic        cb_prefix;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] imm;
    logic [2:0]  step;
    logic        exec_valid;
    logic [15:0] pc;
    logic        halted;

    typedef struct packed {
        logic [7:0]  op;
        logic        cb;
        logic [2:0]  stp;
        logic [15:0] immv;
    } exec_t;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_addr [$];
    exec_t       exp_exec [$];
    logic [15:0] model_pc;
    logic [15:0] model_imm;
    int          rd_delay;
    logic [2:0]  pl_step;
    int          vectors;
    int          miscompares;

    microcode_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .control_signals (control_signals),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready),
        .pc_load         (pc_load),
        .pc_load_value   (pc_load_value),
        .irq_pending     (irq_pending),
        .opcode          (opcode),
        .cb_prefix       (cb_prefix),
        .mem_addr        (mem_addr),
        .mem_rd          (mem_rd),
        .imm             (imm),
        .step            (step),
        .exec_valid      (exec_valid),
        .pc              (pc),
        .halted          (halted)
    );

    // Decoder model: [59:57]=steps-1, 56=IMM1, 55=IMM2, 54=HALT
    function automatic logic [59:0] dec(input logic [7:0] op, input logic cb);
        logic [59:0] w;
        w = '0;
        w[7:0] = op;
        if (cb) begin
            if (op == 8'h7C) w[59:57] = 3'd1;
        end else begin
            case (op)
                8'h01: begin w[59:57] = 3'd2; w[56] = 1'b1; w[55] = 1'b1; end
                8'h3E: begin w[59:57] = 3'd1; w[56] = 1'b1; end
                8'h06: w[55] = 1'b1;
                8'h76: w[54] = 1'b1;
                8'hC3: w[59:57] = 3'd2;
                default: ;
            endcase
        end
        return w;
    endfunction

    assign control_signals = dec(opcode, cb_prefix);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder and jump driver, updated just after each rising edge
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_rd) begin
                if (wcnt >= rd_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wcnt      = 0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end
            pc_load = exec_valid && (opcode == 8'hC3) && (step == pl_step);
        end
    end

    // Scoreboard monitor: fetch addresses, address hold during waits, exec words
    initial begin
        logic        prev_wait;
        logic [15:0] prev_addr;
        logic [15:0] ea;
        exec_t       ee;
        exec_t       act;
        prev_wait = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wait = 1'b0;
            end else begin
                if (mem_rd && prev_wait) begin
                    vectors++;
                    if (mem_addr !== prev_addr) begin
                        miscompares++;
                        $display("FAIL addr_hold got=%h expected=%h", mem_addr, prev_addr);
                    end
                end
                prev_wait = mem_rd && !mem_ready;
                prev_addr = mem_addr;
                if (mem_rd && mem_ready) begin
                    vectors++;
                    if (exp_addr.size() == 0) begin
                        miscompares++;
                        $display("FAIL fetch_addr unexpected read got=%h expected=none", mem_addr);
                    end else begin
                        ea = exp_addr.pop_front();
                        if (mem_addr !== ea) begin
                            miscompares++;
                            $display("FAIL fetch_addr got=%h expected=%h", mem_addr, ea);
                        end
                    end
                end
                if (exec_valid) begin
                    vectors++;
                    act = {opcode, cb_prefix, step, imm};
                    if (exp_exec.size() == 0) begin
                        miscompares++;
                        $display("FAIL exec_word unexpected got=%h expected=none", act);
                    end else begin
                        ee = exp_exec.pop_front();
                        if (act !== ee) begin
                            miscompares++;
                            $display("FAIL exec_word {op,cb,step,imm} got=%h expected=%h", act, ee);
                        end
                    end
                end
            end
        end
    end

    // Place one instruction at model_pc and queue its fetches and exec steps
    task automatic put_instr(input logic [7:0] op, input logic cb, input logic [15:0] immv,
                             input bit take, input logic [15:0] target);
        logic [59:0] ctrl;
        exec_t       e;
        ctrl = dec(op, cb);
        if (cb) begin
            mem[model_pc] = 8'hCB;
            exp_addr.push_back(model_pc);
            model_pc++;
        end
        mem[model_pc] = op;
        exp_addr.push_back(model_pc);
        model_pc++;
        if (ctrl[56]) begin
            mem[model_pc] = immv[7:0];
            exp_addr.push_back(model_pc);
            model_pc++;
            model_imm[7:0] = immv[7:0];
            if (ctrl[55]) begin
                mem[model_pc] = immv[15:8];
                exp_addr.push_back(model_pc);
                model_pc++;
                model_imm[15:8] = immv[15:8];
            end
        end
        for (int s = 0; s <= int'(ctrl[59:57]); s++) begin
            e.op   = op;
            e.cb   = cb;
            e.stp  = 3'(s);
            e.immv = model_imm;
            exp_exec.push_back(e);
        end
        if (take) model_pc = target;
    endtask

    task automatic wake();
        @(negedge clk);
        irq_pending = 1'b1;
        @(negedge clk);
        irq_pending = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted && exp_addr.size() == 0 && exp_exec.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [62:0] act;
        bit          ok;
        rst = 1'b1;
        put_instr(8'h00, 1'b0, 16'h0, 1'b0, 16'h0);
        put_instr(8'h76, 1'b0, 16'h0, 1'b0, 16'h0);
        repeat (2) @(negedge clk);
        act = {pc, mem_addr, mem_rd, exec_valid, halted, opcode, cb_prefix, step, imm};
        vectors++;
        if (act !== 63'h0) begin
            miscompares++;
            $display("FAIL reset_values got=%h expected=%h", act, 63'h0);
        end
        rst = 1'b0;
        drain(200, ok);
        vectors++;
        if (!ok || pc !== model_pc) begin
            miscompares++;
            $display("FAIL reset_first_instr done=%0d pc got=%h expected=%h", ok, pc, model_pc);
        end
    endtask

    task automatic test_immediates();
        bit ok;
        rd_delay = 3;
        put_instr(8'h01, 1'b0, 16'h1234, 1'b0, 16'h0);
        put_instr(8'h3E, 1'b0, 16'h0056, 1'b0, 16'h0);
        put_instr(8'h06, 1'b0, 16'hFFFF, 1'b0, 16'h0);
        put_instr(8'h76, 1'b0, 16'h0, 1'b0, 16'h0);
        wake();
        drain(400, ok);
        vectors++;
        if (!ok || imm !== 16'h1256 || pc !== model_pc) begin
            miscompares++;
            $display("FAIL immediates done=%0d imm got=%h expected=1256 pc got=%h expected=%h",
                     ok, imm, pc, model_pc);
        end
        rd_delay = 0;
    endtask

    task automatic test_prefix();
        bit ok;
        put_instr(8'h7C, 1'b1, 16'h0, 1'b0, 16'h0);
        put_instr(8'h76, 1'b0, 16'h0, 1'b0, 16'h0);
        wake();
        drain(200, ok);
        vectors++;
        if (!ok || cb_prefix !== 1'b0 || pc !== model_pc) begin
            miscompares++;
            $display("FAIL prefix done=%0d cb got=%b expected=0 pc got=%h expected=%h",
                     ok, cb_prefix, pc, model_pc);
        end
    endtask

    task automatic test_jump();
        bit ok;
        pc_load_value = 16'h0150;
        pl_step = 3'd1;
        put_instr(8'hC3, 1'b0, 16'h0, 1'b0, 16'h0);
        put_instr(8'h76, 1'b0, 16'h0, 1'b0, 16'h0);
        wake();
        drain(200, ok);
        vectors++;
        if (!ok || pc !== model_pc) begin
            miscompares++;
            $display("FAIL jump_nonfinal done=%0d pc got=%h expected=%h", ok, pc, model_pc);
        end
        pl_step = 3'd2;
        put_instr(8'hC3, 1'b0, 16'h0, 1'b1, 16'h0150);
        put_instr(8'h76, 1'b0, 16'h0, 1'b0, 16'h0);
        wake();
        drain(200, ok);
        vectors++;
        if (!ok || pc !== 16'h0151) begin
            miscompares++;
            $display("FAIL jump_final done=%0d pc got=%h expected=0151", ok, pc);
        end
    endtask

    task automatic test_halt();
        bit          ok;
        logic [15:0] start;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (halted !== 1'b1 || mem_rd !== 1'b0 || pc !== model_pc) begin
                miscompares++;
                $display("FAIL halt_hold halted=%b rd=%b pc=%h expected 1,0,%h",
                         halted, mem_rd, pc, model_pc);
            end
        end
        start = model_pc;
        put_instr(8'h00, 1'b0, 16'h0, 1'b0, 16'h0);
        put_instr(8'h76, 1'b0, 16'h0, 1'b0, 16'h0);
        irq_pending = 1'b1;
        @(negedge clk);
        irq_pending = 1'b0;
        vectors++;
        if (halted !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== start) begin
            miscompares++;
            $display("FAIL halt_wake halted=%b rd=%b addr=%h expected 0,1,%h",
                     halted, mem_rd, mem_addr, start);
        end
        drain(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL halt_resume done got=0 expected=1");
        end
    endtask

    task automatic test_wrap();
        bit ok;
        pc_load_value = 16'hFFFF;
        pl_step = 3'd2;
        put_instr(8'hC3, 1'b0, 16'h0, 1'b1, 16'hFFFF);
        put_instr(8'h00, 1'b0, 16'h0, 1'b0, 16'h0);
        put_instr(8'h76, 1'b0, 16'h0, 1'b0, 16'h0);
        wake();
        drain(200, ok);
        vectors++;
        if (!ok || pc !== 16'h0001) begin
            miscompares++;
            $display("FAIL pc_wrap done=%0d pc got=%h expected=0001", ok, pc);
        end
    endtask

    task automatic test_reset_mid();
        logic [62:0] act;
        bit          reached;
        rd_delay = 6;
        put_instr(8'h01, 1'b0, 16'hBEEF, 1'b0, 16'h0);
        wake();
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_addr.size() == 1) begin
                reached = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (!reached || mem_rd !== 1'b1) begin
            miscompares++;
            $display("FAIL imm_hi_wait reached=%0d rd got=%b expected=1", reached, mem_rd);
        end
        rst = 1'b1;
        #1;
        act = {pc, mem_addr, mem_rd, exec_valid, halted, opcode, cb_prefix, step, imm};
        vectors++;
        if (act !== 63'h0) begin
            miscompares++;
            $display("FAIL async_reset got=%h expected=%h", act, 63'h0);
        end
        exp_addr.delete();
        exp_exec.delete();
    endtask

    initial begin
        rst           = 1'b1;
        mem_rdata     = 8'h00;
        mem_ready     = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = 16'h0000;
        irq_pending   = 1'b0;
        model_pc      = 16'h0000;
        model_imm     = 16'h0000;
        rd_delay      = 0;
        pl_step       = 3'd7;
        vectors       = 0;
        miscompares   = 0;
        test_reset();
        test_immediates();
        test_prefix();
        test_jump();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
Instruction fetch/step sequencer that drives the opcode into the microcode decoder and consumes the 60-bit control word it returns. It fetches opcode and immediate bytes over a byte-wide read handshake, tracks the PC and the 0xCB prefix, and steps through the per-opcode execute cycles. It sits between the memory bus interface and the datapath. It produces decoder inputs and sequences the control words the decoder outputs.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
STEP_MSB, 59, MSB of 3-bit field (execute steps minus 1) in control word, bits [59:57]
IMM1_BIT, 56, control bit: one immediate byte follows opcode
IMM2_BIT, 55, control bit: second immediate byte follows (valid only with IMM1)
HALT_BIT, 54, control bit: enter HALT after execute

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
control_signals  in  60  control word from microcode decoder for current opcode
mem_rdata  in  8  read data byte
mem_ready  in  1  read data valid; completes current read
pc_load  in  1  datapath requests jump, sampled on last execute step
pc_load_value  in  16  jump target
irq_pending  in  1  wake from HALT
opcode  out  8  opcode presented to decoder (registered)
cb_prefix  out  1  current opcode is from the 0xCB page
mem_addr  out  16  read address (equals pc during fetch)
mem_rd  out  1  read request
imm  out  16  latched immediate {hi,lo}
step  out  3  current execute step index
exec_valid  out  1  control word valid for datapath this cycle
pc  out  16  program counter
halted  out  1  in HALT state

Behaviour:
- Reset (async): state=FETCH, pc=RESET_PC, opcode=8'h00, cb_prefix=0, imm=0, step=0, exec_valid=0, mem_rd=0, halted=0, mem_addr=RESET_PC.
- States: FETCH, PREFIX, DECODE, IMM_LO, IMM_HI, EXEC, HALT.
- Handshake: in FETCH/PREFIX/IMM_LO/IMM_HI, mem_rd=1 and mem_addr=pc, held stable until a cycle with mem_ready=1. On that edge, the byte is captured and pc increments by 1 with 16-bit wrap (FFFF->0000). mem_ready outside a read state is ignored. mem_rd=0 in DECODE, EXEC and HALT.
- FETCH: on accept, if byte==8'hCB and cb_prefix=0: set cb_prefix=1 and go to PREFIX. Otherwise latch opcode and go to DECODE.
- PREFIX: on accept, latch opcode and go to DECODE. cb_prefix stays 1.
- DECODE: one cycle so the decoder output settles. Next state is IMM_LO if IMM1_BIT is set, else EXEC with step=0.
- IMM_LO: accept sets imm[7:0]. Next state is IMM_HI if IMM2_BIT is set, else EXEC.
- IMM_HI: accept sets imm[15:8], then EXEC.
- EXEC: exec_valid=1 every cycle. step counts 0..N, where N=control_signals[STEP_MSB-:3]. On step==N:
  - if pc_load=1, pc<=pc_load_value;
  - cb_prefix<=0, step<=0;
  - next state is HALT if HALT_BIT is set, else FETCH.
- pc_load is ignored on non-final steps.
- HALT: halted=1. Go to FETCH when irq_pending=1; halted drops in the same transition. pc is unchanged.
- IMM2 without IMM1 is treated as no immediates.
- The control word is sampled only in DECODE, IMM_LO, IMM_HI and EXEC. opcode is stable from DECODE until the next FETCH accept.
- Reset asserted mid-read or mid-EXEC aborts immediately to reset values. No partial PC update.

Test Plan:
- Reset, then feed byte 8'h00 (control word N=0, no imm) with mem_ready=1 immediately -> mem_addr 0000 then 0001; exactly one exec_valid cycle; FETCH at pc=0001.
- Opcode with IMM1+IMM2 and N=2; bytes 34,12 with mem_ready delayed 3 cycles each -> mem_rd and mem_addr held during waits; imm=16'h1234; exec_valid for 3 cycles with step 0,1,2; pc advanced by 3.
- Byte CB then 7C -> cb_prefix=1 with opcode=7C during DECODE/EXEC; cb_prefix=0 after the final step; pc+2.
- Jump opcode with pc_load=1 and pc_load_value=0150 on the final step -> next mem_addr=0150. pc_load on a non-final step -> ignored.
- HALT-bit opcode -> halted=1, mem_rd=0 for 10 cycles; pulse irq_pending -> next cycle FETCH at the unchanged pc.
- pc=FFFF fetch -> pc wraps to 0000. Reset asserted during an IMM_HI wait -> immediate return to pc=RESET_PC with all outputs at reset values.
